alu: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_shifter.sv | 23 ++
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding {funct7[5], funct3} and datapath width shared by the ALU and its control decoder.
package alu_pkg;
   localparam int XLEN = 32;
   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SLL   = 4'b0001,
      ALU_SLT   = 4'b0010,
      ALU_SLTU  = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SRL   = 4'b0101,
      ALU_OR    = 4'b0110,
      ALU_AND   = 4'b0111,
      ALU_SUB   = 4'b1000,
      ALU_PASSB = 4'b1001,
      ALU_SRA   = 4'b1101
   } alu_op_e;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: one right barrel shifter serving SLL (via bit reversal), SRL and SRA.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [WIDTH-1:0]         a,
   input  logic [$clog2(WIDTH)-1:0] shamt,
   input  logic                     left,
   input  logic                     arith,
   output logic [WIDTH-1:0]         y
);
   logic [WIDTH-1:0] a_rev, src, shr, shr_rev;
   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign a_rev[i]   = a[WIDTH-1-i];
      assign shr_rev[i] = shr[WIDTH-1-i];
   end
   always_comb begin
      src = left ? a_rev : a;
      shr = WIDTH'($signed({arith & a[WIDTH-1], src}) >>> shamt);
      y   = left ? shr_rev : shr;
   end
endmodule

// File: rtl/alu.sv
// alu: combinational RV32I ALU with an enable-loaded registered copy of the result.
// Optional Zero/Neg flag outputs are built when ALU_FLAGS_EN is defined.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOp,
   input  logic             en,
   output logic [WIDTH-1:0] ALURes,
   output logic [WIDTH-1:0] ALUResQ
`ifdef ALU_FLAGS_EN
   ,
   output logic             Zero,
   output logic             Neg
`endif
);
   localparam int SW = $clog2(WIDTH);
   logic [WIDTH-1:0] sh_y, res_d, res_q;
   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .a     (A),
      .shamt (B[SW-1:0]),
      .left  (ALUOp == ALU_SLL),
      .arith (ALUOp == ALU_SRA),
      .y     (sh_y)
   );
   always_comb begin
      case (alu_op_e'(ALUOp))
         ALU_ADD:   ALURes = A + B;
         ALU_SUB:   ALURes = A - B;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:   ALURes = sh_y;
         ALU_SLT:   ALURes = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         ALU_SLTU:  ALURes = {{(WIDTH-1){1'b0}}, A < B};
         ALU_XOR:   ALURes = A ^ B;
         ALU_OR:    ALURes = A | B;
         ALU_AND:   ALURes = A & B;
         ALU_PASSB: ALURes = B;
         default:   ALURes = '0;
      endcase
   end
   always_comb res_d = en ? ALURes : res_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) res_q <= '0;
      else        res_q <= res_d;
   assign ALUResQ = res_q;
`ifdef ALU_FLAGS_EN
   assign Zero = ALURes == '0;
   assign Neg  = ALURes[WIDTH-1];
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed spec vectors plus randomized ops checked against an arithmetic reference model.
module tb_alu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] A = '0, B = '0;
   logic [3:0]  ALUOp = '0;
   logic        en = 1'b0;
   logic [31:0] ALURes, ALUResQ;
`ifdef ALU_FLAGS_EN
   logic        Zero, Neg;
`endif
   int total = 0;
   int bad = 0;
   alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .ALUOp   (ALUOp),
      .en      (en),
      .ALURes  (ALURes),
      .ALUResQ (ALUResQ)
`ifdef ALU_FLAGS_EN
      ,
      .Zero    (Zero),
      .Neg     (Neg)
`endif
   );
   always #5 clk = ~clk;
   // Shifts expressed as multiply/divide by powers of two rather than shift operators.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] p;
      p = 32'd1 << (b % 32);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a * p;
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a / p;
         4'b1101: return (a / p) | (a[31] ? ~(32'hFFFF_FFFF / p) : 32'd0);
         4'b0110: return a | b;
         4'b0111: return a & b;
         4'b1001: return b;
         default: return 32'd0;
      endcase
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      ALUOp = op;
      A = a;
      B = b;
      #1;
      check(tag, ALURes, exp);
   endtask
   initial begin
      logic [31:0] exp_q, exp_r;
      #1 rst_n = 1'b0;
      #1 check("reset_q", ALUResQ, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      ALUOp = 4'b0000; A = 32'd1; B = 32'd2;
      @(posedge clk); #1 check("load_q", ALUResQ, 32'd3);
      @(negedge clk);
      en = 1'b0; A = 32'd100; B = 32'd5;
      @(posedge clk); #1 check("hold_q", ALUResQ, 32'd3);
      @(negedge clk);
      en = 1'b1; A = 32'd7; B = 32'd8;
      @(posedge clk); #1 check("load2_q", ALUResQ, 32'd15);
      #2 rst_n = 1'b0;
      #1 check("async_rst_q", ALUResQ, 32'd0);
      check("comb_in_rst", ALURes, 32'd15);
      #1 rst_n = 1'b1;
      en = 1'b0;
      vec("add", 4'b0000, 32'd15, 32'd10, 32'h19);
      vec("add_neg", 4'b0000, 32'hFFFF_FFF1, 32'd10, 32'hFFFF_FFFB);
      vec("sub", 4'b1000, 32'd5, 32'd20, 32'hFFFF_FFF1);
      vec("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
      vec("sub_ovf", 4'b1000, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
      vec("slt_t", 4'b0010, 32'hFFFF_FFFB, 32'd5, 32'd1);
      vec("slt_f", 4'b0010, 32'd10, 32'd5, 32'd0);
      vec("slt_min", 4'b0010, 32'h8000_0000, 32'd0, 32'd1);
      vec("sltu_f", 4'b0011, 32'hFFFF_FFFF, 32'd10, 32'd0);
      vec("sltu_t", 4'b0011, 32'd5, 32'd10, 32'd1);
      vec("sltu_min", 4'b0011, 32'h8000_0000, 32'd0, 32'd0);
      vec("sll", 4'b0001, 32'd4, 32'd2, 32'h10);
      vec("srl", 4'b0101, 32'hFFFF_FFFF, 32'd4, 32'h0FFF_FFFF);
      vec("sra", 4'b1101, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC);
      vec("sll_b33", 4'b0001, 32'd1, 32'h23, 32'h8);
      vec("sra_0", 4'b1101, 32'h8765_4321, 32'h20, 32'h8765_4321);
      vec("sll_0", 4'b0001, 32'h8765_4321, 32'd0, 32'h8765_4321);
      vec("srl_0", 4'b0101, 32'h8765_4321, 32'd0, 32'h8765_4321);
      vec("xor", 4'b0100, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
      vec("or", 4'b0110, 32'hF000_0000, 32'hF, 32'hF000_000F);
      vec("and", 4'b0111, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000);
      vec("passb", 4'b1001, 32'd0, 32'hFFFF_FFE7, 32'hFFFF_FFE7);
      vec("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
`ifdef ALU_FLAGS_EN
      vec("sub_zero", 4'b1000, 32'd7, 32'd7, 32'd0);
      check("zero_set", {31'd0, Zero}, 32'd1);
      check("neg_clr", {31'd0, Neg}, 32'd0);
      vec("sub_neg", 4'b1000, 32'd5, 32'd20, 32'hFFFF_FFF1);
      check("zero_clr", {31'd0, Zero}, 32'd0);
      check("neg_set", {31'd0, Neg}, 32'd1);
`endif
      exp_q = 32'd0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ALUOp = 4'($urandom_range(0, 15));
         A = $urandom;
         B = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (i % 16 == 0) B = A;
         en = 1'($urandom_range(0, 1));
         exp_r = model(ALUOp, A, B);
         #1 check("rand_res", ALURes, exp_r);
`ifdef ALU_FLAGS_EN
         check("rand_zero", {31'd0, Zero}, {31'd0, exp_r == 32'd0});
         check("rand_neg", {31'd0, Neg}, {31'd0, exp_r[31]});
`endif
         if (en) exp_q = exp_r;
         @(posedge clk);
         #1 check("rand_q", ALUResQ, exp_q);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
